fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between RAM read port 1 and the decode stage. Generates sequential fetch addresses, tracks the one-cycle RAM read latency, and buffers up to DEPTH fetched instructions with their addresses. Presents the oldest instruction to id under the global pause/flush/jump controls. Decouples fetch from decode stalls while keeping one instruction per cycle in steady state.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0: first fetch address after reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- pause  in  1  decode stalled; head entry is held, not consumed.
- flush  in  1  discard queue contents and the in-flight read.
- jump  in  1  redirect fetch.
- jump_addr  in  32  redirect target; bits [1:0] forced to 0.
- ram_addr  out  32  RAM port-1 read address; equals fetch_pc (combinational).
- ram_data  in  32  RAM port-1 data for the address presented in the previous cycle.
- inst  out  32  head instruction; `INST_NOP when queue empty.
- inst_addr  out  32  address of head instruction; 0 when empty.
- inst_valid  out  1  queue non-empty.

## Operation
- State:
  - fetch_pc, 32 bits.
  - inflight flag and inflight_addr: a read was issued last cycle.
  - FIFO of DEPTH {addr, data} entries with rd/wr pointers of log2(DEPTH) bits (natural wrap) and a count of log2(DEPTH)+1 bits.
- pop = inst_valid & !pause.
- Issue:
  - Issue when count + inflight − pop < DEPTH and no flush/jump this cycle.
  - On issue: inflight ← 1, inflight_addr ← fetch_pc, fetch_pc ← fetch_pc + 4 (wraps mod 2^32).
  - Otherwise inflight ← 0 and fetch_pc holds.
- Response: when inflight = 1 and no flush/jump this cycle, push {inflight_addr, ram_data}.
- Push and pop in the same cycle leave count unchanged.
- Push when full is unreachable by the issue rule; an assertion checks it.
- Redirect (jump or flush) in a cycle:
  - FIFO cleared, inflight ← 0, no push, no issue.
  - If jump = 1: fetch_pc ← {jump_addr[31:2], 2'b00}. jump has priority over flush.
  - If flush = 1 and jump = 0 (replay): fetch_pc ← oldest discarded address, taken in order: head addr if count > 0, else inflight_addr if inflight, else fetch_pc unchanged.
- pause has no effect on redirect; pause and flush together still clears the queue.

## Timing
- Reset values:
  - ram_addr = RESET_PC, inst = `INST_NOP, inst_addr = 0, inst_valid = 0.
  - count = 0, pointers = 0, inflight = 0.
- Asynchronous reset mid-operation discards everything. First edge after release issues RESET_PC.
- Latency:
  - Issue at edge N, data captured and pushed at edge N+1, visible on inst/inst_valid after edge N+1.
  - So redirect/reset-release to first inst_valid = 2 cycles. No bypass path from ram_data to inst.
- Throughput: 1 instruction/cycle sustained with pause = 0.
- After pause, up to DEPTH instructions are buffered and then drain at 1/cycle.
- Outputs inst, inst_addr, inst_valid are functions of registered state only.

## Structure
- `XLEN, `XLEN_WIDTH and `INST_NOP come from define/const.v and define/inst.v. Add `FETCH_RESET_PC to define/const.v as the RESET_PC default.
- One sub-module, fetch_fifo:
  - Parameterised width/depth storage with push, pop, clear, count, and head outputs.
  - Async active-low reset; clear takes priority over push.
- fetch_queue holds the pc/inflight/redirect logic (~150 lines). fetch_fifo is ~100 lines.
- Replaces ifu at the rua top level, wired to ram port 1, the id inputs, and the ctrl pause/flush/jump signals.

## Test plan
- Reset release, RESET_PC = 0, pause = 0, RAM word k = k:
  - ram_addr steps 0,4,8,…
  - inst_valid rises 2 cycles after release.
  - inst/inst_addr sequence (0,0),(1,4),(2,8) on consecutive cycles.
- Hold pause high for 10 cycles with DEPTH = 4:
  - Issue stops with exactly 4 entries buffered; ram_addr frozen at 16.
  - inst_addr held at 0.
  - After release: 0,4,8,12,16 on consecutive cycles, no gap or duplicate.
- jump = 1, jump_addr = 0x102 with 2 entries buffered and a read in flight:
  - Next cycle inst_valid = 0 and ram_addr = 0x100.
  - Two cycles later inst_addr = 0x100; no stale instruction appears.
- flush = 1, jump = 0 with head inst_addr = 0x20:
  - Queue empties; ram_addr = 0x20.
  - 0x20 reappears at head 2 cycles later.
- Same-cycle jump = 1, flush = 1, pause = 1, jump_addr = 0x40: queue cleared and fetch resumes at 0x40.
- Pointer wrap and async reset:
  - Run 3·DEPTH+1 instructions with random pause; inst_addr stays strictly +4 monotonic.
  - Assert rst low mid-stream: outputs go immediately to reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP       = 32'h0000_0013;
    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO holding fetched {addr, data} entries; clear beats push and pop.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        push_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        head_data,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;
    logic              full;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; occupancy is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(do_push && full));

endmodule

// File: rtl/fetch_queue.sv
// Sequential fetch address generator with one-cycle RAM latency tracking and a
// small prefetch buffer feeding decode under pause/flush/jump control.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        flush,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_data,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        inst_valid
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   next_pc;
    logic [31:0]   inflight_addr;
    logic          inflight;
    logic          redirect;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          empty;
    logic [63:0]   head_bits;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign redirect   = jump | flush;
    assign inst_valid = ~empty;
    assign pop        = inst_valid & ~pause;
    assign push       = inflight & ~redirect;

    // Entries buffered plus the read still in flight must leave room for its data.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue     = ~redirect && (occupancy < (DEPTH_W + {{CW{1'b0}}, pop}));

    assign push_entry = '{addr: inflight_addr, data: ram_data};
    assign head       = fetch_entry_t'(head_bits);

    always_comb begin
        next_pc = fetch_pc;
        if (jump) begin
            next_pc = align_word(jump_addr);
        end else if (flush) begin
            // Replay from the oldest instruction that is being thrown away.
            if (!empty)        next_pc = head.addr;
            else if (inflight) next_pc = inflight_addr;
        end else if (issue) begin
            next_pc = fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            fetch_pc <= next_pc;
            inflight <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_addr <= fetch_pc;
    end

    fetch_fifo #(
        .DATA_W ($bits(fetch_entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (redirect),
        .push_data (push_entry),
        .count     (count),
        .head_data (head_bits),
        .empty     (empty)
    );

    assign ram_addr  = fetch_pc;
    assign inst      = empty ? INST_NOP : head.data;
    assign inst_addr = empty ? 32'h0 : head.addr;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model, per-cycle compare, directed and random phases.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pause = 1'b0;
    logic        flush = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic [31:0] ram_data = 32'h0;
    logic [31:0] ram_addr;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state: buffered addresses in order, the pending read, next fetch pc.
    logic [31:0] mq[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_addr = 32'h0;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .flush      (flush),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    // RAM word at byte address a holds a/4, returned one cycle after the address.
    always @(posedge clk) ram_data <= ram_addr >> 2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  occ;
        bit  mpop;
        bit  miss;
        mpop = (mq.size() > 0) && !pause;
        if (jump) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = {jump_addr[31:2], 2'b00};
        end else if (flush) begin
            if (mq.size() > 0) m_pc = mq[0];
            else if (m_infl)   m_pc = m_infl_addr;
            mq.delete();
            m_infl = 1'b0;
        end else begin
            occ  = mq.size() + int'(m_infl) - int'(mpop);
            miss = (occ < DEPTH);
            if (mpop)   void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_addr);
            m_infl = miss;
            if (miss) begin
                m_infl_addr = m_pc;
                m_pc        = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete();
                m_pc   = 32'h0;
                m_infl = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    always @(negedge clk) begin
        check("ram_addr", ram_addr, m_pc);
        check("inst_valid", {31'h0, inst_valid}, {31'h0, mq.size() > 0});
        check("inst_addr", inst_addr, (mq.size() > 0) ? mq[0] : 32'h0);
        check("inst", inst, (mq.size() > 0) ? (mq[0] >> 2) : NOP);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_addr"}, ram_addr, 32'h0);
        check({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
        check({tag, "_inst_addr"}, inst_addr, 32'h0);
        check({tag, "_inst"}, inst, NOP);
    endtask

    logic [31:0] prev_addr;
    bit          have_prev;
    int          r;

    initial begin
        repeat (3) tick();
        check_reset_outputs("rst");

        // Release: fetch 0,4,8..; first valid two edges later.
        rst = 1'b1;
        tick(); check("rel_ram1", ram_addr, 32'h4); check("rel_v1", {31'h0, inst_valid}, 32'h0);
        tick(); check("rel_v2", {31'h0, inst_valid}, 32'h1); check("rel_a2", inst_addr, 32'h0);
                check("rel_i2", inst, 32'h0); check("rel_ram2", ram_addr, 32'h8);
        tick(); check("rel_a3", inst_addr, 32'h4); check("rel_i3", inst, 32'h1);
        tick(); check("rel_a4", inst_addr, 32'h8); check("rel_i4", inst, 32'h2);

        // Asynchronous reset mid-stream, then restart under pause.
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        pause = 1'b1;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        check("pause_ram", ram_addr, 32'h10);
        check("pause_head", inst_addr, 32'h0);
        check("pause_valid", {31'h0, inst_valid}, 32'h1);
        pause = 1'b0;
        tick(); check("drain_4", inst_addr, 32'h4);
        tick(); check("drain_8", inst_addr, 32'h8);
        tick(); check("drain_c", inst_addr, 32'hc);
        tick(); check("drain_10", inst_addr, 32'h10);

        // Jump with entries buffered and a read in flight.
        jump = 1'b1; jump_addr = 32'h102;
        tick(); jump = 1'b0;
        check("jmp_valid", {31'h0, inst_valid}, 32'h0);
        check("jmp_ram", ram_addr, 32'h100);
        tick(); check("jmp_nostale", {31'h0, inst_valid}, 32'h0);
        tick(); check("jmp_head", inst_addr, 32'h100); check("jmp_inst", inst, 32'h40);

        // Flush replays from the head address.
        jump = 1'b1; jump_addr = 32'h20;
        tick(); jump = 1'b0;
        tick(); tick();
        check("pre_flush_head", inst_addr, 32'h20);
        flush = 1'b1;
        tick(); flush = 1'b0;
        check("flush_valid", {31'h0, inst_valid}, 32'h0);
        check("flush_ram", ram_addr, 32'h20);
        tick(); check("flush_gap", {31'h0, inst_valid}, 32'h0);
        tick(); check("flush_head", inst_addr, 32'h20); check("flush_inst", inst, 32'h8);

        // Jump, flush and pause together.
        jump = 1'b1; flush = 1'b1; pause = 1'b1; jump_addr = 32'h40;
        tick(); jump = 1'b0; flush = 1'b0; pause = 1'b0;
        check("jfp_valid", {31'h0, inst_valid}, 32'h0);
        check("jfp_ram", ram_addr, 32'h40);
        tick(); tick();
        check("jfp_head", inst_addr, 32'h40); check("jfp_inst", inst, 32'h10);

        // Random pause only: head advances strictly by 4 through pointer wraps.
        have_prev = 1'b0;
        prev_addr = 32'h0;
        repeat (200) begin
            pause = ($urandom_range(0, 1) == 1);
            tick();
            if (inst_valid) begin
                if (have_prev && inst_addr != prev_addr)
                    check("monotonic", inst_addr, prev_addr + 32'd4);
                prev_addr = inst_addr;
                have_prev = 1'b1;
            end
        end

        // Random redirects, including addresses near the top of the space.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            pause     = (r < 40);
            jump      = (r >= 90) && (r < 95);
            flush     = (r >= 95);
            jump_addr = (r[0]) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            if (i == 300) begin
                jump = 1'b0; flush = 1'b0;
                rst = 1'b0;
                #1;
                check_reset_outputs("rnd_rst");
                tick(); tick();
                rst = 1'b1;
            end
            tick();
        end
        pause = 1'b0; jump = 1'b0; flush = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
